instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
// - Downstream of the AXIS fetch unit. On a start pulse (VALID_FU2PE), it walks the instruction BRAM from address 0.
// - Per instruction, streams len_m1+1 operand pairs from mat A/B BRAMs (same address) to the PE array over a valid/ready handshake.
// - Stops at a HALT or illegal opcode. Sits between the BRAM read ports and the PE lanes.
// PARAMETERS
// - BRAM_DEPTH        10  matrix BRAM address width; must be <=10 (instruction base field is 10b)
// - INSTR_BRAM_DEPTH  11  instruction BRAM address width (pc width)
// PORTS
// - S_AXIS_ACLK     in   1   clock, all logic rising-edge
// - S_AXIS_ARESETN  in   1   reset, asynchronous assert, active-low
// - start           in   1   1-cycle pulse (VALID_FU2PE); ignored while busy=1
// - instr_addr      out  INSTR_BRAM_DEPTH  instruction BRAM read address (= pc)
// - instr_en        out  1   instruction BRAM read enable
// - instr_dout      in   32  instruction read data, valid 1 cycle after instr_en
// - mat_addr        out  BRAM_DEPTH  read address to both mat A and mat B BRAMs
// - mat_en          out  1   matrix BRAM read enable
// - mat_a_dout      in   32  A data, 1-cycle latency
// - mat_b_dout      in   32  B data, 1-cycle latency
// - pe_valid        out  1   operand pair presented
// - pe_ready        in   1   PE accepts when pe_valid&pe_ready
// - pe_opcode       out  4   opcode of current pair
// - pe_a, pe_b      out  32  operands
// - pe_last         out  1   final pair of the current instruction
// - busy            out  1   high from start accept until done
// - done            out  1   1-cycle pulse at program end
// - err_illegal     out  1   sticky; set on illegal opcode, cleared only by the next accepted start
// BEHAVIOUR
// - Reset: state=IDLE, pc=0, all outputs 0, output buffer empty; mid-operation reset aborts immediately with no done pulse.
// - Instr format: [31:28] opcode (0 NOP, 1 ADD, 2 SUB, 3 MUL, F HALT, others illegal), [27:18] len_m1, [9:0] base.
// - FSM: IDLE -start-> FETCH (instr_en=1, addr=pc) -> DECODE (capture instr_dout).
// - DECODE branches:
//   - NOP: pc+1, FETCH.
//   - ADD/SUB/MUL: cnt=0, STREAM.
//   - HALT/illegal: DONE.
// - STREAM: issue a read at mat_addr=base+cnt (mod 2^BRAM_DEPTH) only if buffer occupancy + reads in flight < 2.
//   - Read data lands 1 cycle later in a 2-entry FIFO; the FIFO head drives pe_*.
//   - After issuing cnt==len_m1: go to DRAIN.
// - DRAIN: wait until the pe_last pair is accepted, then pc+1 and FETCH.
// - DONE: done=1 for one cycle, busy=0, go to IDLE. Total latency start->first pe_valid = 4 cycles.
// - pc wrap: an instruction at pc=2^INSTR_BRAM_DEPTH-1 executes, then the block goes to DONE (no wrap to 0).
// - Handshake: pe_valid, once high, holds with pe_a/pe_b/pe_opcode/pe_last stable until accepted; no bubble with pe_ready=1 (1 pair/cycle).
// - Simultaneous FIFO push and pop: occupancy unchanged; a pop when empty is impossible because pe_valid=0.
// - Illegal opcode: err_illegal=1, treated as HALT. start while busy: ignored, no effect.
// CONFIGURATION
// - INSTR_SEQ_PERF_EN defined: adds perf_busy_cycles[31:0] (counts busy cycles) and perf_stalls[31:0] (counts pe_valid&!pe_ready).
//   - Both clear on accepted start and saturate at 0xFFFFFFFF.
// - INSTR_SEQ_PERF_EN undefined: both ports exist, tied to 0, no counter logic.
// TESTING
// - Reset then start; program {ADD len_m1=3 base=0x010, HALT}; pe_ready=1 -> 4 pairs A/B[0x10..0x13], opcode 1, pe_last on 4th, one done, busy low after.
// - Same program with pe_ready toggling 1010... -> each pair held stable while stalled, no loss/duplication, order preserved.
// - Program {NOP, MUL len_m1=0 base=0x3FF, SUB len_m1=1 base=0x3FF, HALT} -> MUL at 0x3FF; SUB reads 0x3FF then 0x000 (wrap); done once.
// - Program {opcode 0x7} -> no pe_valid, err_illegal=1, done pulse; next start clears err_illegal.
// - Assert reset during STREAM of len_m1=100 -> all outputs 0 asynchronously, no done; next start replays from pc=0.
// - INSTR_SEQ_PERF_EN build, 4-pair ADD with 3 stall cycles -> perf_stalls=3, perf_busy_cycles=total busy cycles; undefined build reads 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks the instruction BRAM from pc=0 and streams operand pairs from the mat A/B BRAMs to the PE array.
// Optional build macro INSTR_SEQ_PERF_EN adds busy-cycle and stall performance counters.
module instr_sequencer #(
    parameter int unsigned BRAM_DEPTH       = 10,  // must be <= 10, the instruction base field is 10 bits
    parameter int unsigned INSTR_BRAM_DEPTH = 11
) (
    input  logic                        S_AXIS_ACLK,
    input  logic                        S_AXIS_ARESETN,
    input  logic                        start,
    output logic [INSTR_BRAM_DEPTH-1:0] instr_addr,
    output logic                        instr_en,
    input  logic [31:0]                 instr_dout,
    output logic [BRAM_DEPTH-1:0]       mat_addr,
    output logic                        mat_en,
    input  logic [31:0]                 mat_a_dout,
    input  logic [31:0]                 mat_b_dout,
    output logic                        pe_valid,
    input  logic                        pe_ready,
    output logic [3:0]                  pe_opcode,
    output logic [31:0]                 pe_a,
    output logic [31:0]                 pe_b,
    output logic                        pe_last,
    output logic                        busy,
    output logic                        done,
    output logic                        err_illegal,
    output logic [31:0]                 perf_busy_cycles,
    output logic [31:0]                 perf_stalls
);

    localparam int unsigned OP_W  = 4;
    localparam int unsigned LEN_W = 10;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h3;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [INSTR_BRAM_DEPTH-1:0] PC_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] opcode;
        logic            last;
        logic [31:0]     a;
        logic [31:0]     b;
    } pair_t;

    state_t                      state;
    logic [INSTR_BRAM_DEPTH-1:0] pc;
    logic [OP_W-1:0]             op_q;
    logic [LEN_W-1:0]            len_q;
    logic [LEN_W-1:0]            cnt_q;
    logic [BRAM_DEPTH-1:0]       base_q;
    logic                        land_q;
    logic                        land_last_q;
    pair_t                       head_q;
    pair_t                       tail_q;
    logic                        head_v;
    logic                        tail_v;

    logic            start_acc;
    logic            pop;
    logic            push;
    logic            issue;
    logic            issue_last;
    logic [1:0]      slots;
    pair_t           in_pair;
    logic [OP_W-1:0] dec_op;
    logic            unused_bits;

    assign dec_op      = instr_dout[31:28];
    assign unused_bits = ^instr_dout[17:10];
    assign start_acc   = start && ((state == S_IDLE) || (state == S_DONE));
    assign pop         = head_v && pe_ready;
    assign push        = land_q;

    // Read issue: buffer slots still free after this cycle's pop, counting the read now landing.
    always_comb begin
        slots      = 2'(head_v) + 2'(tail_v) + 2'(land_q) - 2'(pop);
        issue      = (state == S_STREAM) && (slots < 2'd2);
        issue_last = issue && (cnt_q == len_q);
    end

    // Matrix read port is driven combinationally so the pop can free a slot in the same cycle (1 pair/cycle).
    assign mat_en   = issue;
    assign mat_addr = issue ? (base_q + BRAM_DEPTH'(cnt_q)) : '0;

    assign in_pair    = '{opcode: op_q, last: land_last_q, a: mat_a_dout, b: mat_b_dout};
    assign instr_addr = pc;
    assign pe_valid   = head_v;
    assign pe_opcode  = head_q.opcode;
    assign pe_a       = head_q.a;
    assign pe_b       = head_q.b;
    assign pe_last    = head_q.last;

    // Control FSM with registered busy/done/err/instr_en.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state       <= S_IDLE;
            pc          <= '0;
            op_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            base_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            instr_en    <= 1'b0;
        end else begin
            done     <= 1'b0;
            instr_en <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state       <= S_FETCH;
                        pc          <= '0;
                        busy        <= 1'b1;
                        err_illegal <= 1'b0;
                        instr_en    <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    op_q   <= dec_op;
                    len_q  <= instr_dout[27:18];
                    base_q <= BRAM_DEPTH'(instr_dout[9:0]);
                    cnt_q  <= '0;
                    unique case (dec_op)
                        OP_NOP: begin
                            if (pc == PC_LAST) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state    <= S_FETCH;
                                pc       <= pc + INSTR_BRAM_DEPTH'(1);
                                instr_en <= 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB, OP_MUL: state <= S_STREAM;
                        OP_HALT: begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                        default: begin
                            state       <= S_DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            err_illegal <= 1'b1;
                        end
                    endcase
                end
                S_STREAM: begin
                    if (issue) begin
                        cnt_q <= cnt_q + LEN_W'(1);
                    end
                    if (issue_last) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && head_q.last) begin
                        if (pc == PC_LAST) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            pc       <= pc + INSTR_BRAM_DEPTH'(1);
                            instr_en <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read-in-flight tracking and the 2-entry output FIFO; head feeds the PE lanes directly.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            land_q      <= 1'b0;
            land_last_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            head_v      <= 1'b0;
            tail_v      <= 1'b0;
        end else begin
            land_q      <= issue;
            land_last_q <= issue_last;
            unique case ({push, pop})
                2'b10: begin
                    if (!head_v) begin
                        head_q <= in_pair;
                        head_v <= 1'b1;
                    end else begin
                        tail_q <= in_pair;
                        tail_v <= 1'b1;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    head_v <= tail_v;
                    tail_v <= 1'b0;
                end
                2'b11: begin
                    if (tail_v) begin
                        head_q <= tail_q;
                        tail_q <= in_pair;
                    end else begin
                        head_q <= in_pair;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INSTR_SEQ_PERF_EN
    // Saturating counters, cleared by an accepted start.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            perf_busy_cycles <= '0;
            perf_stalls      <= '0;
        end else if (start_acc) begin
            perf_busy_cycles <= '0;
            perf_stalls      <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + CNT_W'(1);
            end
            if (head_v && !pe_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + CNT_W'(1);
            end
        end
    end
`else
    assign perf_busy_cycles = '0;
    assign perf_stalls      = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: BRAM models, a PE-side consumer with selectable ready patterns, and scoreboard checks.
module tb_instr_sequencer;

    localparam int unsigned BD = 10;
    localparam int unsigned ID = 11;
    localparam logic [31:0] HALT = 32'hF000_0000;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [ID-1:0] instr_addr;
    logic          instr_en;
    logic [31:0]   instr_dout = '0;
    logic [BD-1:0] mat_addr;
    logic          mat_en;
    logic [31:0]   mat_a_dout = '0;
    logic [31:0]   mat_b_dout = '0;
    logic          pe_valid;
    logic          pe_ready = 1'b1;
    logic [3:0]    pe_opcode;
    logic [31:0]   pe_a;
    logic [31:0]   pe_b;
    logic          pe_last;
    logic          busy;
    logic          done;
    logic          err_illegal;
    logic [31:0]   perf_busy_cycles;
    logic [31:0]   perf_stalls;

    instr_sequencer #(.BRAM_DEPTH(BD), .INSTR_BRAM_DEPTH(ID)) dut (
        .S_AXIS_ACLK      (clk),
        .S_AXIS_ARESETN   (rst_n),
        .start            (start),
        .instr_addr       (instr_addr),
        .instr_en         (instr_en),
        .instr_dout       (instr_dout),
        .mat_addr         (mat_addr),
        .mat_en           (mat_en),
        .mat_a_dout       (mat_a_dout),
        .mat_b_dout       (mat_b_dout),
        .pe_valid         (pe_valid),
        .pe_ready         (pe_ready),
        .pe_opcode        (pe_opcode),
        .pe_a             (pe_a),
        .pe_b             (pe_b),
        .pe_last          (pe_last),
        .busy             (busy),
        .done             (done),
        .err_illegal      (err_illegal),
        .perf_busy_cycles (perf_busy_cycles),
        .perf_stalls      (perf_stalls)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // BRAM models: matrix contents are a pure function of the address.
    logic [31:0] imem [0:2047];
    always @(posedge clk) begin
        if (instr_en) instr_dout <= imem[instr_addr];
        if (mat_en) begin
            mat_a_dout <= 32'hAA00_0000 | 32'(mat_addr);
            mat_b_dout <= 32'hBB00_0000 | 32'(mat_addr);
        end
    end

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [9:0] len, input logic [9:0] base);
        return {op, len, 8'h00, base};
    endfunction

    task automatic fill_imem(input logic [31:0] w);
        for (int i = 0; i < 2048; i++) imem[i] = w;
    endtask

    // Consumer: ready pattern, hold-stability checks, accepted-pair scoreboard.
    int          ready_mode = 0;
    int          stall_left = 0;
    logic        tgl = 1'b1;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          valid_cycles = 0;
    int          first_valid_cyc = -1;
    logic        held = 1'b0;
    logic [31:0] held_a, held_b, held_ol;
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic [31:0] q_ol [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            case (ready_mode)
                1: begin
                    pe_ready = tgl;
                    tgl      = ~tgl;
                end
                2: begin
                    if (pe_valid && stall_left > 0) begin
                        pe_ready = 1'b0;
                        stall_left--;
                    end else begin
                        pe_ready = 1'b1;
                    end
                end
                default: pe_ready = 1'b1;
            endcase
            if (held) begin
                check("hold_valid", 32'(pe_valid), 32'd1);
                check("hold_a", pe_a, held_a);
                check("hold_b", pe_b, held_b);
                check("hold_op_last", {27'd0, pe_opcode, pe_last}, held_ol);
            end
            held    = pe_valid && !pe_ready;
            held_a  = pe_a;
            held_b  = pe_b;
            held_ol = {27'd0, pe_opcode, pe_last};
            if (pe_valid) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (pe_valid && pe_ready) begin
                q_a.push_back(pe_a);
                q_b.push_back(pe_b);
                q_ol.push_back({27'd0, pe_opcode, pe_last});
            end
            if (done) done_cnt++;
        end else begin
            held = 1'b0;
        end
    end

    task automatic start_prog();
        @(posedge clk);
        q_a.delete();
        q_b.delete();
        q_ol.delete();
        done_cnt        = 0;
        valid_cycles    = 0;
        first_valid_cyc = -1;
        tgl             = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_pair(input string tag, input int idx, input logic [3:0] op,
                              input logic [9:0] addr, input logic last);
        check({tag, "_a"}, q_a[idx], 32'hAA00_0000 | 32'(addr));
        check({tag, "_b"}, q_b[idx], 32'hBB00_0000 | 32'(addr));
        check({tag, "_op_last"}, q_ol[idx], {27'd0, op, last});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_imem(HALT);
        repeat (3) @(negedge clk);
        check("rst_ctrl", 32'({busy, done, pe_valid, pe_last, err_illegal, instr_en, mat_en}), 32'd0);
        check("rst_instr_addr", 32'(instr_addr), 32'd0);
        check("rst_pe_a", pe_a, 32'd0);
        check("rst_perf", perf_busy_cycles | perf_stalls, 32'd0);
        rst_n = 1'b1;

        // ADD len 4 at 0x010, ready always high
        imem[0] = ins(4'h1, 10'd3, 10'h010);
        imem[1] = HALT;
        ready_mode = 0;
        start_prog();
        check("t1_busy", 32'(busy), 32'd1);
        wait_done("t1", 100);
        check("t1_npairs", 32'(q_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_pair("t1", i, 4'h1, 10'(10'h010 + i), i == 3);
        check("t1_latency", 32'(first_valid_cyc - start_cyc), 32'd4);
        check("t1_err", 32'(err_illegal), 32'd0);
`ifdef INSTR_SEQ_PERF_EN
        check("t1_perf_busy", perf_busy_cycles, 32'd10);
`else
        check("t1_perf_busy", perf_busy_cycles, 32'd0);
`endif
        check("t1_perf_stall", perf_stalls, 32'd0);

        // Same program, ready toggling 1010...
        ready_mode = 1;
        start_prog();
        wait_done("t2", 100);
        check("t2_npairs", 32'(q_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_pair("t2", i, 4'h1, 10'(10'h010 + i), i == 3);

        // NOP, MUL at top of matrix space, SUB wrapping to 0
        ready_mode = 0;
        imem[0] = 32'h0000_0000;
        imem[1] = ins(4'h3, 10'd0, 10'h3FF);
        imem[2] = ins(4'h2, 10'd1, 10'h3FF);
        imem[3] = HALT;
        start_prog();
        wait_done("t3", 100);
        check("t3_npairs", 32'(q_a.size()), 32'd3);
        check_pair("t3_mul", 0, 4'h3, 10'h3FF, 1'b1);
        check_pair("t3_sub0", 1, 4'h2, 10'h3FF, 1'b0);
        check_pair("t3_sub1", 2, 4'h2, 10'h000, 1'b1);

        // Illegal opcode, then a start clears the sticky error
        fill_imem(HALT);
        imem[0] = 32'h7000_0000;
        start_prog();
        wait_done("t4", 50);
        check("t4_no_valid", 32'(valid_cycles), 32'd0);
        check("t4_err", 32'(err_illegal), 32'd1);
        imem[0] = HALT;
        start_prog();
        check("t5_err_cleared", 32'(err_illegal), 32'd0);
        wait_done("t5", 50);

        // Asynchronous reset mid-stream, then replay from pc 0
        imem[0] = ins(4'h1, 10'd100, 10'h000);
        imem[1] = HALT;
        start_prog();
        for (int i = 0; i < 60 && q_a.size() < 5; i++) @(posedge clk);
        check("t6_streaming", 32'(q_a.size() >= 5), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 32'({busy, done, pe_valid, pe_last, err_illegal, instr_en, mat_en}), 32'd0);
        check("t6_rst_addr", 32'({instr_addr, mat_addr}), 32'd0);
        check("t6_rst_pe", pe_a | pe_b | 32'(pe_opcode), 32'd0);
        repeat (3) @(negedge clk);
        check("t6_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        imem[0] = ins(4'h1, 10'd3, 10'h020);
        start_prog();
        wait_done("t6r", 100);
        check("t6r_npairs", 32'(q_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_pair("t6r", i, 4'h1, 10'(10'h020 + i), i == 3);

        // Three stall cycles on a 4-pair ADD
        imem[0] = ins(4'h1, 10'd3, 10'h010);
        ready_mode = 2;
        stall_left = 3;
        start_prog();
        wait_done("t7", 100);
        check("t7_npairs", 32'(q_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_pair("t7", i, 4'h1, 10'(10'h010 + i), i == 3);
`ifdef INSTR_SEQ_PERF_EN
        check("t7_perf_stall", perf_stalls, 32'd3);
        check("t7_perf_busy", perf_busy_cycles, 32'd13);
`else
        check("t7_perf_stall", perf_stalls, 32'd0);
        check("t7_perf_busy", perf_busy_cycles, 32'd0);
`endif

        // Last pc executes, then done without wrapping
        ready_mode = 0;
        fill_imem(32'h0000_0000);
        imem[2047] = ins(4'h1, 10'd0, 10'h005);
        start_prog();
        wait_done("t8", 6000);
        check("t8_npairs", 32'(q_a.size()), 32'd1);
        check_pair("t8", 0, 4'h1, 10'h005, 1'b1);
        check("t8_idle_fetch", 32'(instr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
